// File: rtl/fork_arbiter.sv
// Fork scheduler: hands a branch variable to one idle neighbor, round-robin,
// with ack/nack/timeout handling and bounded retries.

module fork_arbiter_lane (
  input  logic sel,
  input  logic send,
  input  logic waiting,
  input  logic ack,
  input  logic nack,
  output logic valid,
  output logic ack_hit,
  output logic nack_hit
);
  assign valid    = send & sel;
  assign ack_hit  = waiting & sel & ack;
  assign nack_hit = waiting & sel & nack;
endmodule

module fork_arbiter #(
  parameter int NUM_NEIGHBORS = 4,
  parameter int VAR_WIDTH     = 8,
  parameter int ACK_TIMEOUT   = 15,
  parameter int MAX_RETRIES   = 3
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     fork_req,
  input  logic [VAR_WIDTH-1:0]     fork_var,
  input  logic [NUM_NEIGHBORS-1:0] neighbor_busy,
  input  logic [NUM_NEIGHBORS-1:0] neighbor_ack,
  input  logic [NUM_NEIGHBORS-1:0] neighbor_nack,
  output logic [NUM_NEIGHBORS-1:0] out_valid,
  output logic [1:0]               out_msg_type,
  output logic [VAR_WIDTH-1:0]     out_var,
  output logic                     busy,
  output logic                     fork_done,
  output logic                     fork_granted,
  output logic [NUM_NEIGHBORS-1:0] fork_target
);
  localparam int PW = (NUM_NEIGHBORS > 1) ? $clog2(NUM_NEIGHBORS) : 1;
  localparam int RW = $clog2(MAX_RETRIES + 1);
  localparam int TW = (ACK_TIMEOUT > 0) ? $clog2(ACK_TIMEOUT + 1) : 1;

  typedef enum logic [2:0] {IDLE, SELECT, SEND, WAIT, DONE} state_t;

  state_t                 state, state_nx;
  logic [PW-1:0]          ptr, ptr_nx, target, target_nx, free_idx, idx;
  logic [RW-1:0]          retry_cnt, retry_nx, retry_inc;
  logic [TW-1:0]          timer, timer_nx;
  logic [VAR_WIDTH-1:0]   var_q, var_nx;
  logic                   granted, granted_nx, found, last_try;
  logic [NUM_NEIGHBORS-1:0] tgt_oh, ack_hit, nack_hit, valid_lane;

  genvar i;
  generate
    for (i = 0; i < NUM_NEIGHBORS; i++) begin : g_lane
      assign tgt_oh[i] = (target == PW'(i));
      fork_arbiter_lane u_lane (
        .sel     (tgt_oh[i]),
        .send    (state == SEND),
        .waiting (state == WAIT),
        .ack     (neighbor_ack[i]),
        .nack    (neighbor_nack[i]),
        .valid   (valid_lane[i]),
        .ack_hit (ack_hit[i]),
        .nack_hit(nack_hit[i])
      );
    end
  endgenerate

  // First free neighbor after ptr, wrapping; works for non-power-of-two counts.
  always_comb begin
    found    = 1'b0;
    free_idx = '0;
    idx      = '0;
    for (int k = 1; k <= NUM_NEIGHBORS; k++) begin
      idx = PW'((int'(ptr) + k) % NUM_NEIGHBORS);
      if (!found && !neighbor_busy[idx]) begin
        found    = 1'b1;
        free_idx = idx;
      end
    end
  end

  assign retry_inc = retry_cnt + RW'(1);
  assign last_try  = (retry_inc == RW'(MAX_RETRIES));

  always_comb begin
    state_nx   = state;
    ptr_nx     = ptr;
    target_nx  = target;
    retry_nx   = retry_cnt;
    timer_nx   = timer;
    var_nx     = var_q;
    granted_nx = granted;
    case (state)
      IDLE: if (fork_req) begin
        var_nx   = fork_var;
        retry_nx = '0;
        state_nx = SELECT;
      end
      SELECT: if (found) begin
        target_nx = free_idx;
        state_nx  = SEND;
      end else begin
        retry_nx = retry_inc;
        if (last_try) begin
          granted_nx = 1'b0;
          state_nx   = DONE;
        end
      end
      SEND: begin
        timer_nx = '0;
        state_nx = WAIT;
      end
      WAIT: if (|ack_hit) begin
        ptr_nx     = target;
        granted_nx = 1'b1;
        state_nx   = DONE;
      end else if (|nack_hit || timer == TW'(ACK_TIMEOUT)) begin
        ptr_nx   = target;
        retry_nx = retry_inc;
        if (last_try) begin
          granted_nx = 1'b0;
          state_nx   = DONE;
        end else begin
          state_nx = SELECT;
        end
      end else begin
        timer_nx = timer + TW'(1);
      end
      DONE: state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      ptr       <= PW'(NUM_NEIGHBORS - 1);
      target    <= '0;
      retry_cnt <= '0;
      timer     <= '0;
      var_q     <= '0;
      granted   <= 1'b0;
    end else begin
      state     <= state_nx;
      ptr       <= ptr_nx;
      target    <= target_nx;
      retry_cnt <= retry_nx;
      timer     <= timer_nx;
      var_q     <= var_nx;
      granted   <= granted_nx;
    end
  end

  assign out_valid    = valid_lane;
  assign out_msg_type = (state == SEND) ? 2'b01 : 2'b00;
  assign out_var      = (state == SEND) ? var_q : '0;
  assign busy         = (state != IDLE);
  assign fork_done    = (state == DONE);
  assign fork_granted = (state == DONE) && granted;
  assign fork_target  = ((state == DONE) && granted) ? tgt_oh : '0;
endmodule

// File: tb/tb_fork_arbiter.sv
// Directed bench for fork_arbiter: table of fork scenarios plus hand-written
// latency, timeout and reset sequences.

module tb_fork_arbiter;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       fork_req = 1'b0;
  logic [7:0] fork_var = '0;
  logic [3:0] neighbor_busy = '0, neighbor_ack = '0, neighbor_nack = '0;
  logic [3:0] out_valid, fork_target;
  logic [1:0] out_msg_type;
  logic [7:0] out_var;
  logic       busy, fork_done, fork_granted;

  int n_pass = 0, n_tot = 0;

  fork_arbiter #(.NUM_NEIGHBORS(4), .VAR_WIDTH(8), .ACK_TIMEOUT(15), .MAX_RETRIES(3)) dut (
    .clk(clk), .rst_n(rst_n), .fork_req(fork_req), .fork_var(fork_var),
    .neighbor_busy(neighbor_busy), .neighbor_ack(neighbor_ack), .neighbor_nack(neighbor_nack),
    .out_valid(out_valid), .out_msg_type(out_msg_type), .out_var(out_var), .busy(busy),
    .fork_done(fork_done), .fork_granted(fork_granted), .fork_target(fork_target)
  );

  always #5 clk = ~clk;

  localparam logic [1:0] R_ACK = 2'd0, R_NACK = 2'd1, R_SIL = 2'd2, R_BOTH = 2'd3;

  typedef struct {
    logic [7:0]      v;
    logic [3:0]      nbusy;
    logic [2:0][1:0] resp;   // response per send attempt, resp[0] first
    logic [3:0]      stray;  // extra ack bits driven with the first response
    logic [3:0]      first;  // expected first FORK destination (0 = none)
    logic            granted;
    logic [3:0]      target;
    int              sends;
    int              cyc;    // expected fork_done cycle, 1 = cycle after fork_req edge
  } vec_t;

  vec_t tbl[8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tot++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
    else n_pass++;
  endtask

  task automatic run_fork(input int n);
    vec_t t;
    int   cyc, sends;
    bit   pend, done;
    logic [3:0] tgt;
    t = tbl[n];
    sends = 0; pend = 0; done = 0; tgt = '0;
    @(negedge clk);
    fork_req = 1'b1; fork_var = t.v; neighbor_busy = t.nbusy;
    @(negedge clk);
    fork_req = 1'b0; cyc = 1;
    while (!done && cyc <= 40) begin
      neighbor_ack = '0; neighbor_nack = '0;
      if (pend) begin
        pend = 0;
        if (sends >= 1 && sends <= 3) begin
          case (t.resp[sends-1])
            R_ACK:  neighbor_ack = tgt;
            R_NACK: neighbor_nack = tgt;
            R_BOTH: begin neighbor_ack = tgt; neighbor_nack = tgt; end
            default: ;
          endcase
          if (sends == 1) neighbor_ack = neighbor_ack | t.stray;
        end
      end
      if (out_valid != 0) begin
        sends++;
        if (sends == 1) chk($sformatf("v%0d first_target", n), out_valid, t.first);
        chk($sformatf("v%0d msg_type", n), out_msg_type, 2'b01);
        chk($sformatf("v%0d out_var", n), out_var, t.v);
        tgt = out_valid; pend = 1;
      end
      if (fork_done) begin
        done = 1;
        chk($sformatf("v%0d granted", n), fork_granted, t.granted);
        chk($sformatf("v%0d target", n), fork_target, t.target);
        chk($sformatf("v%0d sends", n), sends, t.sends);
        chk($sformatf("v%0d done_cycle", n), cyc, t.cyc);
      end else begin
        @(negedge clk); cyc++;
      end
    end
    if (!done) chk($sformatf("v%0d done_seen", n), 0, 1);
    neighbor_ack = '0; neighbor_nack = '0;
    @(negedge clk);
    chk($sformatf("v%0d busy_after", n), busy, 1'b0);
    chk($sformatf("v%0d done_after", n), fork_done, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int gap;
    tbl[0] = '{v:8'h11, nbusy:4'b0000, resp:{R_SIL,R_SIL,R_ACK},   stray:4'b0000, first:4'b0010, granted:1'b1, target:4'b0010, sends:1, cyc:4};
    tbl[1] = '{v:8'h22, nbusy:4'b0000, resp:{R_SIL,R_SIL,R_ACK},   stray:4'b0000, first:4'b0100, granted:1'b1, target:4'b0100, sends:1, cyc:4};
    tbl[2] = '{v:8'h33, nbusy:4'b0110, resp:{R_SIL,R_SIL,R_ACK},   stray:4'b0000, first:4'b1000, granted:1'b1, target:4'b1000, sends:1, cyc:4};
    tbl[3] = '{v:8'h55, nbusy:4'b0000, resp:{R_SIL,R_SIL,R_BOTH},  stray:4'b0000, first:4'b0100, granted:1'b1, target:4'b0100, sends:1, cyc:4};
    tbl[4] = '{v:8'h66, nbusy:4'b0000, resp:{R_SIL,R_ACK,R_NACK},  stray:4'b0001, first:4'b1000, granted:1'b1, target:4'b0001, sends:2, cyc:7};
    tbl[5] = '{v:8'h88, nbusy:4'b0000, resp:{R_SIL,R_SIL,R_ACK},   stray:4'b0000, first:4'b0001, granted:1'b1, target:4'b0001, sends:1, cyc:4};
    tbl[6] = '{v:8'h77, nbusy:4'b0000, resp:{R_NACK,R_NACK,R_NACK},stray:4'b0000, first:4'b0010, granted:1'b0, target:4'b0000, sends:3, cyc:10};
    tbl[7] = '{v:8'hAA, nbusy:4'b1111, resp:{R_ACK,R_ACK,R_ACK},   stray:4'b0000, first:4'b0000, granted:1'b0, target:4'b0000, sends:0, cyc:4};

    // Reset state
    #12;
    chk("rst busy", busy, 1'b0);
    chk("rst out_valid", out_valid, 4'b0);
    chk("rst msg_type", out_msg_type, 2'b0);
    chk("rst fork_done", fork_done, 1'b0);
    @(negedge clk); rst_n = 1'b1;

    // Basic grant with exact cycle latency
    @(negedge clk); fork_req = 1'b1; fork_var = 8'h42; neighbor_busy = 4'b0000;
    @(negedge clk); fork_req = 1'b0;
    chk("basic c1 busy", busy, 1'b1);
    chk("basic c1 out_valid", out_valid, 4'b0);
    @(negedge clk);
    chk("basic c2 out_valid", out_valid, 4'b0001);
    chk("basic c2 msg_type", out_msg_type, 2'b01);
    chk("basic c2 out_var", out_var, 8'h42);
    @(negedge clk);
    chk("basic c3 out_valid", out_valid, 4'b0);
    chk("basic c3 out_var", out_var, 8'h00);
    neighbor_ack = 4'b0001;
    @(negedge clk); neighbor_ack = '0;
    chk("basic c4 done", fork_done, 1'b1);
    chk("basic c4 granted", fork_granted, 1'b1);
    chk("basic c4 target", fork_target, 4'b0001);
    @(negedge clk);
    chk("basic c5 busy", busy, 1'b0);
    chk("basic c5 done", fork_done, 1'b0);

    for (int n = 0; n < 3; n++) run_fork(n);

    // Silent target: 16 WAIT cycles + 1 SELECT before the retry FORK
    @(negedge clk); fork_req = 1'b1; fork_var = 8'h44; neighbor_busy = 4'b0000;
    @(negedge clk); fork_req = 1'b0;
    @(negedge clk);
    chk("tmo first target", out_valid, 4'b0001);
    gap = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (out_valid != 0) break;
      gap++;
    end
    chk("tmo gap cycles", gap, 17);
    chk("tmo retry target", out_valid, 4'b0010);
    @(negedge clk); neighbor_ack = 4'b0010;
    @(negedge clk); neighbor_ack = '0;
    chk("tmo done", fork_done, 1'b1);
    chk("tmo granted", fork_granted, 1'b1);
    chk("tmo target", fork_target, 4'b0010);
    @(negedge clk);

    for (int n = 3; n < 5; n++) run_fork(n);

    // Reset while waiting on neighbor 1
    @(negedge clk); fork_req = 1'b1; fork_var = 8'h99; neighbor_busy = 4'b0000;
    @(negedge clk); fork_req = 1'b0;
    @(negedge clk);
    chk("rstw target", out_valid, 4'b0010);
    @(negedge clk);
    chk("rstw busy in wait", busy, 1'b1);
    @(negedge clk); rst_n = 1'b0;
    #1;
    chk("rstw busy", busy, 1'b0);
    chk("rstw out_valid", out_valid, 4'b0);
    chk("rstw out_var", out_var, 8'h00);
    chk("rstw fork_done", fork_done, 1'b0);
    chk("rstw granted", fork_granted, 1'b0);
    chk("rstw target_out", fork_target, 4'b0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("rstw no done", fork_done, 1'b0);
    end
    rst_n = 1'b1;

    for (int n = 5; n < 8; n++) run_fork(n);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule

// File: doc/fork_arbiter.md
Name: fork_arbiter

Overview:
- Per-node scheduler that hands a forked sub-problem (branch variable) from the local SAT node to one idle neighbor.
- Picks among non-busy neighbors round-robin and drives a one-cycle FORK message to the chosen neighbor.
- Waits for accept/reject with a timeout and retries up to a bound.
- Reports the outcome back to the node. Sits between node and the neighbor links in the swarm fabric.

Parameters:
- NUM_NEIGHBORS, 4: number of neighbor links.
- VAR_WIDTH, 8: branch variable width.
- ACK_TIMEOUT, 15: WAIT cycles before a silent neighbor counts as a reject; WAIT lasts at most ACK_TIMEOUT+1 cycles.
- MAX_RETRIES, 3: total selection/send attempts before giving up. Must be at least 1.

Ports:
- clk, in, 1: clock; all state changes on the rising edge.
- rst_n, in, 1: asynchronous, active-low reset.
- fork_req, in, 1: node requests a fork; sampled only in IDLE.
- fork_var, in, VAR_WIDTH: branch variable; latched when fork_req is accepted.
- neighbor_busy, in, NUM_NEIGHBORS: bit i=1 means neighbor i cannot take work.
- neighbor_ack, in, NUM_NEIGHBORS: neighbor i accepted the fork.
- neighbor_nack, in, NUM_NEIGHBORS: neighbor i rejected the fork.
- out_valid, out, NUM_NEIGHBORS: one-hot strobe of the FORK message to a neighbor.
- out_msg_type, out, 2: 2'b01 (FORK) while any out_valid bit is set, else 2'b00.
- out_var, out, VAR_WIDTH: latched branch variable while out_valid is set, else 0.
- busy, out, 1: high in every state except IDLE.
- fork_done, out, 1: one-cycle completion pulse.
- fork_granted, out, 1: valid with fork_done; 1 = accepted, 0 = gave up.
- fork_target, out, NUM_NEIGHBORS: one-hot accepting neighbor, valid with fork_done; 0 when not granted.

Behaviour:
- Moore FSM with states IDLE, SELECT, SEND, WAIT, DONE. All outputs decode from registered state and registers.
- Reset (asynchronous, any state, including mid-operation):
  - state=IDLE; all outputs 0; retry_cnt=0; timer=0; latched var=0.
  - Round-robin pointer ptr=NUM_NEIGHBORS-1, so neighbor 0 has first priority.
  - An in-flight fork is silently dropped; no fork_done is issued.
- IDLE:
  - If fork_req=1: latch fork_var, set retry_cnt=0, go to SELECT.
  - A held fork_req starts a new fork on the first IDLE cycle after DONE.
- SELECT:
  - Free set is ~neighbor_busy. Search for the first free index starting at ptr+1, wrapping modulo NUM_NEIGHBORS.
  - If found: register it as target, go to SEND.
  - If none is free: retry_cnt+1. If the new count equals MAX_RETRIES, go to DONE with granted=0; otherwise stay in SELECT (one cycle per attempt).
- SEND:
  - out_valid[target]=1 for exactly one cycle, with out_msg_type=01 and out_var set to the latched variable.
  - Clear timer, go to WAIT.
- WAIT (only target bits are observed; ack/nack on other bits are ignored):
  - ack[target]: set ptr=target, go to DONE with granted=1. If ack and nack arrive in the same cycle, ack wins.
  - else nack[target], or timer==ACK_TIMEOUT: set ptr=target, retry_cnt+1. If the count equals MAX_RETRIES, go to DONE with granted=0; otherwise go to SELECT.
  - else timer+1.
- DONE:
  - fork_done=1 for one cycle; fork_granted is the result.
  - fork_target = onehot(target) if granted, else 0.
  - Go to IDLE.
- Latency, best case: fork_req sampled at edge 0 → SELECT → out_valid in cycle 2 → ack seen in the first WAIT cycle (3) → fork_done in cycle 4.
- Widths:
  - retry_cnt is clog2(MAX_RETRIES+1) bits.
  - timer is clog2(ACK_TIMEOUT+1) bits and never wraps.
  - The pointer wraps via modulo NUM_NEIGHBORS; NUM_NEIGHBORS is not required to be a power of two.
- busy=1 from the first SELECT cycle through DONE inclusive.

Test Plan:
1. Basic grant:
   - Stimulus: neighbor_busy=0000, fork_req with fork_var=0x42; neighbor 0 acks in the first WAIT cycle.
   - Response: out_valid=0001, type 01, out_var=0x42 for one cycle; fork_done 2 cycles later with granted=1, target=0001.
2. Round-robin:
   - Stimulus: repeat scenario 1 twice with all neighbors free and each target acking.
   - Response: targets are 0010 then 0100.
   - Then set busy=0110 with ptr=2 → target is 1000.
3. All busy:
   - Stimulus: neighbor_busy=1111 held.
   - Response: 3 SELECT cycles, out_valid never asserted, fork_done with granted=0, target=0000, busy=0 the next cycle.
4. Timeout then grant:
   - Stimulus: target 0 stays silent.
   - Response: WAIT lasts 16 cycles; then a FORK goes to neighbor 1, which acks → granted=1, target=0010.
5. Ack/nack edge cases:
   - Stimulus: ack and nack on the target in the same cycle → granted=1.
   - Stimulus: ack on a non-target bit only → ignored; nack on the target → retry to the next neighbor.
   - Stimulus: 3 nacks in a row → granted=0.
6. Reset mid-WAIT:
   - Stimulus: assert rst_n=0 during WAIT.
   - Response: all outputs 0 immediately, no fork_done. After release, the next fork targets neighbor 0.
